// File: rtl/banco_reg_gen.sv
// banco_reg_gen: register file with two combinational read ports, one write
// port and a zeroing sweep that runs after reset and on every Clear request.
// Optional macro BANCO_REG_BYPASS_EN enables write-first forwarding of
// WriteData onto a read port whose address matches the write address.
module banco_reg_gen #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] AW,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic              Clear,
    output logic [DATA_W-1:0] DR1,
    output logic [DATA_W-1:0] DR2,
    output logic              Ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_ready;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_idle;
    logic w_aw_writable;
    logic w_user_we;
    logic w_rd1_zero;
    logic w_rd2_zero;

    assign w_idle        = (r_state == IDLE);
    assign w_aw_writable = (ZERO_REG == 0) || (AW != '0);
    assign w_user_we     = w_idle && RegWrite && w_aw_writable;
    assign w_rd1_zero    = (ZERO_REG != 0) && (RA1 == '0);
    assign w_rd2_zero    = (ZERO_REG != 0) && (RA2 == '0);

    assign Ready = r_ready;

    // Control FSM: sweep the whole file once, then sit in IDLE until Clear restarts the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                SWEEP: begin
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    if (Clear) begin
                        r_state <= SWEEP;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= SWEEP;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage: the sweep owns the write port while active, user writes only land in IDLE.
    always_ff @(posedge clk) begin
        if (!w_idle) begin
            r_mem[r_cnt] <= '0;
        end else if (w_user_we) begin
            r_mem[AW] <= WriteData;
        end
    end

    // Read port 1: zero while sweeping or for the hardwired register, optional forwarding.
    always_comb begin
        DR1 = '0;
        if (w_idle && !w_rd1_zero) begin
            DR1 = r_mem[RA1];
`ifdef BANCO_REG_BYPASS_EN
            if (w_user_we && (AW == RA1)) begin
                DR1 = WriteData;
            end
`endif
        end
    end

    // Read port 2: same behaviour as port 1, fully independent address.
    always_comb begin
        DR2 = '0;
        if (w_idle && !w_rd2_zero) begin
            DR2 = r_mem[RA2];
`ifdef BANCO_REG_BYPASS_EN
            if (w_user_we && (AW == RA2)) begin
                DR2 = WriteData;
            end
`endif
        end
    end

endmodule

// File: tb/tb_banco_reg_gen.sv
// Scoreboard bench for banco_reg_gen: stimulus pushes expected values, a
// monitor pops and compares them at each falling clock edge or on demand.
module tb_banco_reg_gen;

    localparam int DW = 32;
    localparam int AWD = 5;

    logic           clk;
    logic           rst_n;
    logic           RegWrite;
    logic [AWD-1:0] AW;
    logic [DW-1:0]  WriteData;
    logic [AWD-1:0] RA1;
    logic [AWD-1:0] RA2;
    logic           Clear;
    logic [DW-1:0]  DR1;
    logic [DW-1:0]  DR2;
    logic           Ready;
    logic [DW-1:0]  DR1z;
    logic [DW-1:0]  DR2z;
    logic           Readyz;

    typedef struct {
        string      name;
        int         kind;
        logic [31:0] expVal;
    } expT;

    expT scoreQ[$];
    int  assertions = 0;
    int  failures   = 0;
    event probeEv;

    banco_reg_gen #(.DATA_W(DW), .ADDR_W(AWD), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .AW(AW),
        .WriteData(WriteData), .RA1(RA1), .RA2(RA2), .Clear(Clear),
        .DR1(DR1), .DR2(DR2), .Ready(Ready)
    );

    banco_reg_gen #(.DATA_W(DW), .ADDR_W(AWD), .ZERO_REG(0)) dutZ (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .AW(AW),
        .WriteData(WriteData), .RA1(RA1), .RA2(RA2), .Clear(Clear),
        .DR1(DR1z), .DR2(DR2z), .Ready(Readyz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pushExp(input string name, input int kind, input logic [31:0] v);
        expT e;
        e.name   = name;
        e.kind   = kind;
        e.expVal = v;
        scoreQ.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [AWD-1:0] aw, input logic [DW-1:0] wd,
                                 input logic [AWD-1:0] ra1, input logic [AWD-1:0] ra2, input logic clr);
        RegWrite  = we;
        AW        = aw;
        WriteData = wd;
        RA1       = ra1;
        RA2       = ra2;
        Clear     = clr;
    endtask

    // kind: 0 Ready, 1 DR1, 2 DR2, 3 DR1 of the ZERO_REG=0 instance
    task automatic checkOutput(input expT e);
        logic [31:0] act;
        case (e.kind)
            0:       act = {31'b0, Ready};
            1:       act = DR1;
            2:       act = DR2;
            default: act = DR1z;
        endcase
        assertions++;
        if (act !== e.expVal) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h", e.name, act, e.expVal);
        end
    endtask

    initial begin
        expT e;
        forever begin
            @(negedge clk or probeEv);
            while (scoreQ.size() > 0) begin
                e = scoreQ.pop_front();
                checkOutput(e);
            end
        end
    end

    // Full sweep: Ready low for 32 samples then high; writes and Clear during it are ignored.
    task automatic sweepCheck(input string tag);
        for (int k = 0; k <= 32; k++) begin
            applyStimulus(k < 32, 5'(k) | 5'd1, 32'hFFFF0000 | k, 5'(k), ~5'(k),
                          (k < 32) && (k % 7 == 3));
            pushExp({tag, "_ready"}, 0, (k == 32) ? 32'd1 : 32'd0);
            pushExp({tag, "_dr1"}, 1, 32'd0);
            pushExp({tag, "_dr2"}, 2, 32'd0);
            pushExp({tag, "_dr1z"}, 3, 32'd0);
            cycle();
        end
    endtask

    task automatic readAllZero(input string tag);
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, '0, '0, 5'(a), 5'(31 - a), 1'b0);
            pushExp({tag, "_dr1"}, 1, 32'd0);
            pushExp({tag, "_dr2"}, 2, 32'd0);
            pushExp({tag, "_dr1z"}, 3, 32'd0);
            cycle();
        end
    endtask

    initial begin
        logic [31:0] expByp;
        rst_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 5'd3, 5'd4, 1'b0);

        // Reset state
        cycle();
        cycle();
        pushExp("reset_ready", 0, 32'd0);
        pushExp("reset_dr1", 1, 32'd0);
        pushExp("reset_dr2", 2, 32'd0);
        cycle();

        // Initial sweep after release
        rst_n = 1'b1;
        sweepCheck("init_sweep");
        readAllZero("init_read");

        // Simple write then dual-port read
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd9, 5'd9, 1'b0);
        pushExp("pre_write_dr1", 1, 32'd0);
        cycle();
        applyStimulus(1'b0, '0, '0, 5'd5, 5'd5, 1'b0);
        pushExp("rd5_dr1", 1, 32'hDEADBEEF);
        pushExp("rd5_dr2", 2, 32'hDEADBEEF);
        cycle();

        // Same-cycle forwarding behaviour
`ifdef BANCO_REG_BYPASS_EN
        expByp = 32'hA5A5A5A5;
`else
        expByp = 32'd0;
`endif
        applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd5, 5'd7, 1'b0);
        pushExp("byp_dr2", 2, expByp);
        pushExp("byp_dr1_other", 1, 32'hDEADBEEF);
        cycle();
        applyStimulus(1'b0, '0, '0, 5'd5, 5'd7, 1'b0);
        pushExp("after_byp_dr2", 2, 32'hA5A5A5A5);
        cycle();

        // Register zero handling
        applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0);
        pushExp("zr_same_dr1", 1, 32'd0);
        pushExp("zr_same_dr1z", 3, expByp == 32'd0 ? 32'd0 : 32'h12345678);
        cycle();
        applyStimulus(1'b0, '0, '0, 5'd0, 5'd0, 1'b0);
        pushExp("zr_dr1", 1, 32'd0);
        pushExp("zr_dr2", 2, 32'd0);
        pushExp("zr_dr1z", 3, 32'h12345678);
        cycle();

        // Fill 1..31 and read back a few
        for (int a = 1; a < 32; a++) begin
            applyStimulus(1'b1, 5'(a), 32'h10000000 + a * 32'h0101, '0, '0, 1'b0);
            cycle();
        end
        applyStimulus(1'b0, '0, '0, 5'd1, 5'd31, 1'b0);
        pushExp("fill_dr1_1", 1, 32'h10000101);
        pushExp("fill_dr2_31", 2, 32'h10001F1F);
        cycle();
        applyStimulus(1'b0, '0, '0, 5'd15, 5'd3, 1'b0);
        pushExp("fill_dr1z_15", 3, 32'h10000F0F);
        pushExp("fill_dr2_3", 2, 32'h10000303);
        cycle();

        // Clear together with a write: write lands, sweep then wipes it
        applyStimulus(1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd1, 1'b0);
        Clear = 1'b1;
        pushExp("clr_ready", 0, 32'd1);
        pushExp("clr_dr1", 1, expByp == 32'd0 ? 32'h10000303 : 32'hCAFEF00D);
        cycle();
        sweepCheck("clr_sweep");
        readAllZero("clr_read");

        // Async reset while IDLE with nonzero data on the outputs
        applyStimulus(1'b1, 5'd5, 32'h55AA55AA, '0, '0, 1'b0);
        cycle();
        applyStimulus(1'b0, '0, '0, 5'd5, 5'd5, 1'b0);
        pushExp("pre_rst_dr1", 1, 32'h55AA55AA);
        pushExp("pre_rst_ready", 0, 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        pushExp("arst_idle_ready", 0, 32'd0);
        pushExp("arst_idle_dr1", 1, 32'd0);
        pushExp("arst_idle_dr2", 2, 32'd0);
        -> probeEv;
        cycle();
        cycle();
        rst_n = 1'b1;
        sweepCheck("rst_sweep");

        // Async reset in the middle of a sweep
        applyStimulus(1'b1, 5'd9, 32'h99999999, 5'd9, 5'd9, 1'b1);
        cycle();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, '0, '0, 5'd9, 5'd9, 1'b0);
            pushExp("mid_sweep_ready", 0, 32'd0);
            cycle();
        end
        #1;
        rst_n = 1'b0;
        #1;
        pushExp("arst_sweep_ready", 0, 32'd0);
        pushExp("arst_sweep_dr1", 1, 32'd0);
        -> probeEv;
        cycle();
        cycle();
        rst_n = 1'b1;
        sweepCheck("resweep");
        applyStimulus(1'b0, '0, '0, 5'd5, 5'd9, 1'b0);
        pushExp("final_dr1_5", 1, 32'd0);
        pushExp("final_dr2_9", 2, 32'd0);
        cycle();

        @(negedge clk);
        #1;
        assertions++;
        if (scoreQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL queue_drain: actual=%0d required=0", scoreQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/banco_reg_gen.md
BANCO_REG_GEN -- requirements
Module: banco_reg_gen

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 is hardwired to zero.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 RegWrite  input  1  write enable.
REQ-007 AW  input  ADDR_W  write address.
REQ-008 WriteData  input  DATA_W  write data.
REQ-009 RA1  input  ADDR_W  read address, port 1.
REQ-010 RA2  input  ADDR_W  read address, port 2.
REQ-011 Clear  input  1  request to zero the whole file.
REQ-012 DR1  output  DATA_W  read data, port 1.
REQ-013 DR2  output  DATA_W  read data, port 2.
REQ-014 Ready  output  1  high when the file accepts writes and returns valid reads.

Function
REQ-015 The block SHALL implement a two-state FSM, SWEEP and IDLE, with an ADDR_W-bit sweep counter.
REQ-016 In SWEEP, each cycle SHALL write zero to entry[counter], then increment the counter; when counter = DEPTH-1 is written, the FSM SHALL go to IDLE next cycle (sweep = DEPTH cycles).
REQ-017 In SWEEP, Ready SHALL be 0, DR1/DR2 SHALL read 0, and RegWrite SHALL be ignored (no write, no bypass).
REQ-018 In IDLE, Ready SHALL be 1; Clear=1 at a rising edge SHALL reset the counter to 0 and enter SWEEP next cycle; Clear in SWEEP SHALL be ignored.
REQ-019 Clear and RegWrite in the same IDLE cycle: the write SHALL be performed, then the sweep SHALL zero it.
REQ-020 In IDLE, RegWrite=1 SHALL write WriteData to entry[AW] at the rising edge (one-cycle latency to storage).
REQ-021 With ZERO_REG=1, writes to AW=0 SHALL be discarded and reads of address 0 SHALL return 0 on both ports; with ZERO_REG=0, entry 0 is an ordinary register.
REQ-022 Reads SHALL be combinational from RA1/RA2; both ports independent; RA1=RA2 permitted.
REQ-023 Counter SHALL not wrap past DEPTH-1 within a sweep; DEPTH=2 (ADDR_W=1) SHALL work.

Reset
REQ-024 rst_n=0 SHALL immediately force FSM to SWEEP, counter to 0, Ready to 0, DR1/DR2 to 0, regardless of clk.
REQ-025 Storage contents SHALL be unspecified during reset; the first sweep after rst_n rises SHALL zero all entries.
REQ-026 Reset asserted mid-sweep or mid-write SHALL abort it; the sweep SHALL restart from entry 0 after release.

Configuration
REQ-027 Macro BANCO_REG_BYPASS_EN: when defined, in IDLE with RegWrite=1, AW=RAx and AW a writable address, DRx SHALL return WriteData in the same cycle (write-first forwarding).
REQ-028 Without BANCO_REG_BYPASS_EN, DRx SHALL return the stored value; new data visible from the cycle after the write edge.

Verification
REQ-029 Release rst_n, hold Clear=0 -> Ready=0 for exactly 32 cycles (defaults), then 1; reads of all 32 addresses return 0.
REQ-030 IDLE: write 0xDEADBEEF to AW=5, then RA1=5, RA2=5 -> both ports 0xDEADBEEF next cycle.
REQ-031 ZERO_REG=1: write 0x12345678 to AW=0, read RA1=0 -> 0x00000000; with ZERO_REG=0 -> 0x12345678.
REQ-032 Bypass build: RegWrite=1, AW=7, WriteData=0xA5A5A5A5, RA2=7 same cycle -> DR2=0xA5A5A5A5 before the edge; non-bypass build -> old value 0.
REQ-033 Fill registers 1..31 with nonzero data, pulse Clear 1 cycle -> Ready low 32 cycles, then all reads 0; RegWrite during sweep leaves no trace.
REQ-034 Assert rst_n=0 asynchronously at sweep count 10 -> Ready and DR1/DR2 go 0 without a clock edge; after release sweep lasts a full 32 cycles.
